// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Purpose  : Shared constants and types for the forwarding / hazard unit.
//            - FWD_SEL_RF / FWD_SEL_STAGE0 : forward-select encodings
//            - sb_entry_t                  : one long-latency scoreboard entry
// Revision : 1.0  initial release
// ============================================================================
package fwd_pkg;

  // Forward-select encoding: 0 = register file, k+1 = downstream stage k.
  localparam int unsigned FWD_SEL_RF     = 0;
  localparam int unsigned FWD_SEL_STAGE0 = 1;

  // Field widths of a scoreboard entry. The hazard unit's REG_AW / LAT_W
  // parameters are expected to match these.
  localparam int unsigned SB_REG_AW = 5;
  localparam int unsigned SB_LAT_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic [SB_REG_AW-1:0] rd;
    logic [SB_LAT_W-1:0]  cnt;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_ll_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ll_scoreboard
// Purpose  : Tracks in-flight long-latency writes (mul/div, load miss).
//            Allocates the lowest free entry on issue, counts each entry down
//            to writeback, and reports which source registers are still busy.
// Ports    : clk, rst_n          clock, async active-low reset
//            issue_i/rd_i/lat_i  long-latency op leaving EX this cycle
//            src_rs_i            source addresses to test (packed per operand)
//            src_busy_o          per-source: matches a valid entry
//            ready_o             at least one entry free (registered state)
//            overflow_o          sticky: issue attempted while full
// Revision : 1.0  initial release
// ============================================================================
module ll_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_PEND = 4,
  parameter int unsigned LAT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_i,
  input  logic [REG_AW-1:0]         issue_rd_i,
  input  logic [LAT_W-1:0]          issue_lat_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_rs_i,
  output logic [NUM_SRC-1:0]        src_busy_o,
  output logic                      ready_o,
  output logic                      overflow_o
);

  sb_entry_t           entry_q [NUM_PEND];
  sb_entry_t           entry_d [NUM_PEND];
  logic                overflow_q;
  logic                overflow_d;
  logic [NUM_PEND-1:0] w_free;
  logic                w_req;
  logic [LAT_W-1:0]    w_lat;

  // Free means invalid in registered state; an entry retiring this cycle is
  // still valid here and therefore not reusable until the next cycle.
  always_comb begin : p_free
    for (int j = 0; j < NUM_PEND; j++) begin
      w_free[j] = ~entry_q[j].valid;
    end
  end

  // x0 writes carry no dependency and are never tracked.
  assign w_req = issue_i & (issue_rd_i != '0);
  assign w_lat = (issue_lat_i == '0) ? LAT_W'(1) : issue_lat_i;

  always_comb begin : p_next
    logic taken;
    taken      = 1'b0;
    overflow_d = overflow_q;
    for (int j = 0; j < NUM_PEND; j++) begin
      entry_d[j] = entry_q[j];
      if (entry_q[j].valid) begin
        if (entry_q[j].cnt == SB_LAT_W'(1)) begin
          entry_d[j] = '0;
        end else begin
          entry_d[j].cnt = entry_q[j].cnt - SB_LAT_W'(1);
        end
      end else if (w_req && !taken) begin
        entry_d[j].valid = 1'b1;
        entry_d[j].rd    = SB_REG_AW'(issue_rd_i);
        entry_d[j].cnt   = SB_LAT_W'(w_lat);
        taken            = 1'b1;
      end
    end
    if (w_req && !(|w_free)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      for (int j = 0; j < NUM_PEND; j++) begin
        entry_q[j] <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_PEND; j++) begin
        entry_q[j] <= entry_d[j];
      end
      overflow_q <= overflow_d;
    end
  end

  // Any valid entry with the same rd keeps the source busy, so duplicate
  // (WAW) entries hold the stall until the last one retires.
  always_comb begin : p_match
    for (int i = 0; i < NUM_SRC; i++) begin
      src_busy_o[i] = 1'b0;
      for (int j = 0; j < NUM_PEND; j++) begin
        if (entry_q[j].valid &&
            (entry_q[j].rd == SB_REG_AW'(src_rs_i[i*REG_AW +: REG_AW])) &&
            (src_rs_i[i*REG_AW +: REG_AW] != '0)) begin
          src_busy_o[i] = 1'b1;
        end
      end
    end
  end

  assign ready_o    = |w_free;
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Operand forwarding selects for NUM_SRC sources from NUM_FWD
//            downstream stages, plus load-use and long-latency stall
//            detection. Selects are computed in ID and registered into EX.
// Ports    : clk, rst_n                       clock, async active-low reset
//            id_valid_i/id_rs_i/id_rs_used_i  ID instruction and sources
//            ex_*_i                           EX-stage destination info
//            fwd_regwrite_i/fwd_rd_i          downstream stage k writers
//            ll_issue_i/ll_rd_i/ll_lat_i      long-latency issue
//            flush_i                          kill ID/EX contents
//            stall_o                          combinational stall request
//            fwd_sel_ex_o                     registered select per operand
//            ll_ready_o/ll_overflow_o         scoreboard status
//            stall_cycles_o                   saturating stall-cycle count
// Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned REG_AW   = SB_REG_AW,
  parameter int unsigned NUM_PEND = 4,
  parameter int unsigned LAT_W    = SB_LAT_W,
  parameter int unsigned SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_regwrite_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic [NUM_FWD-1:0]        fwd_regwrite_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
  input  logic                      ll_issue_i,
  input  logic [REG_AW-1:0]         ll_rd_i,
  input  logic [LAT_W-1:0]          ll_lat_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_ex_o,
  output logic                      ll_ready_o,
  output logic                      ll_overflow_o,
  output logic [31:0]               stall_cycles_o
);

  logic [NUM_SRC-1:0]       w_active;
  logic [NUM_SRC-1:0]       w_ex_hit;
  logic [NUM_SRC-1:0]       w_load_use;
  logic [NUM_SRC-1:0]       w_sb_stall;
  logic [NUM_SRC-1:0]       w_src_busy;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
  logic [31:0]              stall_cycles_d;
  logic [31:0]              stall_cycles_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0]  w_rs;
    logic [NUM_FWD-1:0] w_fwd_hit;
    logic [SEL_W-1:0]   w_sel;
    logic               w_unused_last;

    assign w_rs        = id_rs_i[i*REG_AW +: REG_AW];
    assign w_active[i] = id_valid_i & id_rs_used_i[i] & (w_rs != '0);
    assign w_ex_hit[i] = ex_valid_i & ex_regwrite_i & (ex_rd_i == w_rs);

    for (genvar k = 0; k < NUM_FWD; k++) begin : g_stage
      assign w_fwd_hit[k] = fwd_regwrite_i[k] &
                            (fwd_rd_i[k*REG_AW +: REG_AW] == w_rs);
    end

    // The last stage writes the register file in the same cycle the operand
    // is read (write-through), so it never needs a forward path.
    assign w_unused_last = w_fwd_hit[NUM_FWD-1];

    // Youngest producer wins: EX first, then the lowest downstream stage.
    // Each producer advances one stage before the consumer reaches EX,
    // hence EX -> stage 0 and stage k -> stage k+1.
    always_comb begin : p_sel
      w_sel = SEL_W'(FWD_SEL_RF);
      if (w_ex_hit[i] && !ex_is_load_i) begin
        w_sel = SEL_W'(FWD_SEL_STAGE0);
      end else begin
        for (int k = int'(NUM_FWD) - 2; k >= 0; k--) begin
          if (w_fwd_hit[k]) begin
            w_sel = SEL_W'(k + 2);
          end
        end
      end
      if (!w_active[i]) begin
        w_sel = SEL_W'(FWD_SEL_RF);
      end
    end

    assign w_fwd_sel[i*SEL_W +: SEL_W] = w_sel;
    assign w_load_use[i] = w_active[i] & w_ex_hit[i] & ex_is_load_i;
    assign w_sb_stall[i] = w_active[i] & w_src_busy[i];
  end

  ll_scoreboard #(
    .NUM_SRC  (NUM_SRC),
    .REG_AW   (REG_AW),
    .NUM_PEND (NUM_PEND),
    .LAT_W    (LAT_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_i     (ll_issue_i),
    .issue_rd_i  (ll_rd_i),
    .issue_lat_i (ll_lat_i),
    .src_rs_i    (id_rs_i),
    .src_busy_o  (w_src_busy),
    .ready_o     (ll_ready_o),
    .overflow_o  (ll_overflow_o)
  );

  assign w_stall = |(w_load_use | w_sb_stall);

  // A stalled or flushed ID sends a bubble into EX, which reads nothing.
  assign fwd_sel_d      = (flush_i || w_stall) ? '0 : w_fwd_sel;
  assign stall_cycles_d = (w_stall && (stall_cycles_q != '1)) ?
                          stall_cycles_q + 32'd1 : stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      fwd_sel_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      fwd_sel_q      <= fwd_sel_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_o        = w_stall;
  assign fwd_sel_ex_o   = fwd_sel_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Self-checking bench for fwd_hazard_unit. A driver issues
//            directed and random stimulus and pushes the expected outputs
//            from a behavioural model into a queue; a separate monitor pops
//            and compares them against the DUT every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int NUM_SRC  = 2;
  localparam int NUM_FWD  = 2;
  localparam int REG_AW   = 5;
  localparam int NUM_PEND = 4;
  localparam int LAT_W    = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic                      ex_valid, ex_regwrite, ex_is_load;
  logic [REG_AW-1:0]         ex_rd;
  logic [NUM_FWD-1:0]        fwd_regwrite;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic                      ll_issue;
  logic [REG_AW-1:0]         ll_rd;
  logic [LAT_W-1:0]          ll_lat;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel_ex;
  logic                      ll_ready, ll_overflow;
  logic [31:0]               stall_cycles;

  always #10 clk = ~clk;

  fwd_hazard_unit #(
    .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW),
    .NUM_PEND(NUM_PEND), .LAT_W(LAT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(id_rs_used),
    .ex_valid_i(ex_valid), .ex_regwrite_i(ex_regwrite),
    .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd),
    .fwd_regwrite_i(fwd_regwrite), .fwd_rd_i(fwd_rd),
    .ll_issue_i(ll_issue), .ll_rd_i(ll_rd), .ll_lat_i(ll_lat),
    .flush_i(flush),
    .stall_o(stall), .fwd_sel_ex_o(fwd_sel_ex),
    .ll_ready_o(ll_ready), .ll_overflow_o(ll_overflow),
    .stall_cycles_o(stall_cycles)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic                 stall;
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                 ready;
    logic                 ovf;
    logic [31:0]          scnt;
    int                   cyc;
  } exp_t;

  typedef struct {
    logic [REG_AW-1:0] rd;
    int                rem;   // cycles still in flight
  } pend_t;

  exp_t                     expq[$];
  pend_t                    m_pend[$];
  logic [NUM_SRC*SEL_W-1:0] m_sel;
  logic                     m_ovf;
  logic [31:0]              m_scnt;
  int                       cyc = 0;
  int                       checks = 0;
  int                       errors = 0;

  function automatic logic [REG_AW-1:0] rs_of(input int i);
    return id_rs[i*REG_AW +: REG_AW];
  endfunction

  function automatic logic src_live(input int i);
    return id_valid && id_rs_used[i] && (rs_of(i) != '0);
  endfunction

  function automatic logic model_stall();
    logic s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_live(i)) begin
        if (ex_valid && ex_regwrite && ex_is_load && ex_rd == rs_of(i)) s = 1'b1;
        foreach (m_pend[p]) if (m_pend[p].rd == rs_of(i)) s = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [NUM_SRC*SEL_W-1:0] model_sel();
    logic [NUM_SRC*SEL_W-1:0] r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int v = 0;
      if (src_live(i)) begin
        if (ex_valid && ex_regwrite && !ex_is_load && ex_rd == rs_of(i)) begin
          v = 1;
        end else begin
          for (int k = 0; k < NUM_FWD - 1; k++) begin
            if (fwd_regwrite[k] && fwd_rd[k*REG_AW +: REG_AW] == rs_of(i)) begin
              v = k + 2;
              break;
            end
          end
        end
      end
      r[i*SEL_W +: SEL_W] = SEL_W'(v);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_sel  = '0;
    m_ovf  = 1'b0;
    m_scnt = '0;
  endtask

  task automatic model_edge(input logic st);
    pend_t nq[$];
    pend_t np;
    int    old_n = m_pend.size();
    foreach (m_pend[p]) begin
      if (m_pend[p].rem > 1) begin
        np = m_pend[p];
        np.rem = np.rem - 1;
        nq.push_back(np);
      end
    end
    if (ll_issue && ll_rd != '0) begin
      if (old_n < NUM_PEND) begin
        np.rd  = ll_rd;
        np.rem = (ll_lat == '0) ? 1 : int'(ll_lat);
        nq.push_back(np);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_pend = nq;
    m_sel  = (flush || st) ? '0 : model_sel();
    if (st && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
  endtask

  task automatic push_expect(output logic st);
    exp_t e;
    st      = model_stall();
    e.stall = st;
    e.sel   = m_sel;
    e.ready = (m_pend.size() < NUM_PEND);
    e.ovf   = m_ovf;
    e.scnt  = m_scnt;
    e.cyc   = cyc;
    expq.push_back(e);
  endtask

  // Inputs are already driven at this falling edge; record expectation,
  // advance the model over the coming rising edge, move to next falling edge.
  task automatic step();
    logic st;
    push_expect(st);
    model_edge(st);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0h expected=%0h", nm, c, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall",        32'(stall),        32'(e.stall), e.cyc);
        chk("fwd_sel_ex",   32'(fwd_sel_ex),   32'(e.sel),   e.cyc);
        chk("ll_ready",     32'(ll_ready),     32'(e.ready), e.cyc);
        chk("ll_overflow",  32'(ll_overflow),  32'(e.ovf),   e.cyc);
        chk("stall_cycles", stall_cycles,      e.scnt,       e.cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    ex_valid = 1'b0; ex_regwrite = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    fwd_regwrite = '0; fwd_rd = '0;
    ll_issue = 1'b0; ll_rd = '0; ll_lat = '0;
    flush = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used);
    id_valid = 1'b1; id_rs = {r1, r0}; id_rs_used = used;
  endtask

  task automatic set_ex(input logic load, input logic [4:0] rd);
    ex_valid = 1'b1; ex_regwrite = 1'b1; ex_is_load = load; ex_rd = rd;
  endtask

  task automatic set_fwd(input logic [1:0] rw, input logic [4:0] rd0,
                         input logic [4:0] rd1);
    fwd_regwrite = rw; fwd_rd = {rd1, rd0};
  endtask

  task automatic set_ll(input logic [4:0] rd, input logic [3:0] lat);
    ll_issue = 1'b1; ll_rd = rd; ll_lat = lat;
  endtask

  // Reset asserted between clock edges while a stall is in progress.
  task automatic async_reset_mid();
    logic st;
    push_expect(st);
    #6 rst_n = 1'b0;
    #1;
    chk("arst_stall",        32'(stall),       32'd0, cyc);
    chk("arst_fwd_sel_ex",   32'(fwd_sel_ex),  32'd0, cyc);
    chk("arst_ll_ready",     32'(ll_ready),    32'd1, cyc);
    chk("arst_ll_overflow",  32'(ll_overflow), 32'd0, cyc);
    chk("arst_stall_cycles", stall_cycles,     32'd0, cyc);
    model_reset();
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  initial begin : driver
    idle();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    idle(); step();

    // ALU dependency through EX, then through stage 0
    idle(); set_ex(1'b0, 5'd5); set_id(5'd5, 5'd0, 2'b01); step();
    idle(); set_fwd(2'b01, 5'd5, 5'd0); set_id(5'd0, 5'd5, 2'b10); step();
    idle(); step();

    // load-use: one stall cycle, then forward from downstream
    idle(); set_ex(1'b1, 5'd7); set_id(5'd7, 5'd0, 2'b01); step();
    idle(); set_fwd(2'b01, 5'd7, 5'd0); set_id(5'd7, 5'd0, 2'b01); step();
    idle(); step();

    // priority and x0
    idle(); set_ex(1'b0, 5'd3); set_fwd(2'b01, 5'd3, 5'd0); set_id(5'd3, 5'd0, 2'b01); step();
    idle(); set_fwd(2'b01, 5'd3, 5'd0); set_id(5'd3, 5'd0, 2'b01); step();
    idle(); set_ex(1'b1, 5'd0); set_fwd(2'b11, 5'd0, 5'd0); set_id(5'd0, 5'd0, 2'b11); step();
    idle(); step();

    // long latency, then lat=0 treated as 1
    idle(); set_ll(5'd9, 4'd4); step();
    repeat (6) begin idle(); set_id(5'd0, 5'd9, 2'b10); step(); end
    idle(); set_ll(5'd11, 4'd0); step();
    repeat (3) begin idle(); set_id(5'd11, 5'd0, 2'b01); step(); end

    // fill the scoreboard, overflow, drain
    for (int r = 0; r < 4; r++) begin idle(); set_ll(5'(12 + r), 4'd15); step(); end
    idle(); set_ll(5'd20, 4'd15); step();
    repeat (18) begin idle(); step(); end

    // flush during a scoreboard stall
    idle(); set_ll(5'd10, 4'd3); step();
    idle(); set_id(5'd10, 5'd0, 2'b01); flush = 1'b1; step();
    repeat (4) begin idle(); set_id(5'd10, 5'd0, 2'b01); step(); end

    // async reset with nonzero select, live stall and sticky overflow
    idle(); set_ex(1'b0, 5'd5); set_id(5'd5, 5'd0, 2'b01); set_ll(5'd9, 4'd8); step();
    idle(); set_id(5'd0, 5'd9, 2'b10); async_reset_mid();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used   = 2'($urandom);
      ex_valid     = 1'($urandom);
      ex_regwrite  = 1'($urandom);
      ex_is_load   = ($urandom_range(0, 3) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      fwd_regwrite = 2'($urandom);
      fwd_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ll_issue     = ($urandom_range(0, 5) == 0);
      ll_rd        = 5'($urandom_range(0, 7));
      ll_lat       = 4'($urandom);
      flush        = ($urandom_range(0, 7) == 0);
      step();
    end

    idle();
    repeat (2) @(negedge clk);
    #5;
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
